matrix_frame_scanner: RTL and testbench
=======================================

Name: matrix_frame_scanner

Overview:
- Double-buffered 8x8 RGB frame store for the game's LED matrix.
- Game logic writes pixels into the back buffer and requests a swap. The block reads the front buffer row by row and drives the active-low colour columns and the 3-bit row select.
- It sits between the game/state logic and the matrix pins, replacing ad-hoc per-object multiplexing.

Parameters:
- ROW_CYCLES, 2500, CLK cycles a row is lit (SHOW phase), min 2.
- BLANK_CYCLES, 16, CLK cycles all columns are off before each row (ghosting guard), min 1.

Ports:
- CLK  in  1  system clock.
- Clear  in  1  asynchronous reset, active-low.
- wr_en  in  1  write one pixel of the back buffer this cycle.
- wr_row  in  3  pixel row (y), 0..7.
- wr_col  in  3  pixel column (x), 0..7.
- wr_rgb  in  3  pixel colour: bit2=R, bit1=G, bit0=B; 1=lit.
- wr_clr  in  1  one-cycle pulse; clears the whole back buffer.
- swap_req  in  1  level request to exchange front and back buffers.
- swap_ack  out  1  one-cycle pulse; swap performed.
- busy  out  1  back-buffer clear in progress.
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of row 0.
- position_R/position_G/position_B  out  8 each  column drives, active-low; bit i = column i.
- S  out  3  row select.

Behaviour:
- Reset (Clear=0, async):
  - Both buffers zero; front index 0; scan state BLANK; row 0; dwell counter 0.
  - position_R/G/B = 8'hFF; S = 0.
  - swap_ack, busy, frame_start = 0.
- Scan FSM, states BLANK and SHOW:
  - BLANK: all position_* = 8'hFF; S = current row. Lasts BLANK_CYCLES, then go to SHOW.
  - SHOW: position_X = ~front[row].X, registered, so columns change on the first SHOW cycle. Lasts ROW_CYCLES, then go to BLANK with row+1.
  - Row wraps 7 to 0; one frame = 8*(ROW_CYCLES+BLANK_CYCLES) cycles.
- Frame boundary = the last SHOW cycle of row 7.
  - If swap_req=1 and busy=0 there, toggle the front index on that clock edge and pulse swap_ack the following cycle.
  - Otherwise the swap is deferred to the next boundary.
- swap_req is level-sensitive. The requester must drop it on seeing swap_ack; if it is still high at the next boundary, another swap occurs.
- Writes:
  - wr_en updates back[wr_row][wr_col] = wr_rgb at the clock edge.
  - The front buffer is never writable.
  - A pixel written is displayed only after the next swap.
- wr_en coincident with the swap edge: the write lands in the pre-swap back buffer, so it is visible in the newly displayed frame.
- wr_clr: busy=1 for exactly 8 cycles starting the cycle after the pulse; zeroes back rows 0..7, one per cycle.
  - wr_en while busy is ignored.
  - wr_clr while busy is ignored.
  - wr_clr and wr_en in the same cycle: the clear wins, the write is dropped.
- frame_start pulses on the first SHOW cycle of row 0, in every frame including the first after reset.
- Clear asserted mid-operation aborts any clear or pending swap and returns all state to reset values.

Optional Feature:
- Macro: MATRIX_DIM_EN.
- Defined:
  - Adds input port brightness[2:0].
  - In SHOW, columns are driven only during the first ((brightness+1)*ROW_CYCLES)/8 cycles, integer division, minimum 1 cycle; they are 8'hFF for the rest of the dwell.
  - brightness is sampled at the start of each SHOW.
- Undefined:
  - No brightness port.
  - Columns are lit for the full ROW_CYCLES.

Decomposition:
- Package matrix_pkg:
  - Colour bit indices (R=2, G=1, B=0).
  - Row/column width 3 and matrix size 8.
  - Scan state enum {BLANK, SHOW}.
  - Row-word type (3 colours x 8 bits).
- Sub-module matrix_frame_buf:
  - Holds both buffers, the front index, write, sequential clear and swap.
  - Exposes a combinational row read for the scanner.
- Top level holds the scan FSM, dwell counter, swap arbitration and output registers.

Test Plan (ROW_CYCLES=4, BLANK_CYCLES=2, frame = 48 cycles):
- Reset/scan timing: release Clear, idle inputs -> S steps 0..7 each 6 cycles; 2 cycles at 8'hFF then 4 cycles at 8'hFF; frame_start every 48 cycles.
- Write then swap: write (row3,col5,rgb=3'b100), assert swap_req -> no change before the boundary; swap_ack at the boundary; next frame row-3 SHOW gives position_R=8'b11011111, G=B=8'hFF.
- Clear plus deferral: wr_clr then swap_req 2 cycles later, plus wr_en during busy -> busy high 8 cycles; the ignored write never appears; swap happens at the first boundary after busy falls; the display is all 8'hFF after that swap.
- Mid-frame reset: pull Clear low during row-5 SHOW with swap_req high -> outputs immediately 8'hFF, S=0, no swap_ack; display blank after release.
- Simultaneous write and swap: wr_en (row0,col0,rgb=3'b011) on the swap edge -> following row-0 SHOW gives position_G=position_B=8'b11111110.
- MATRIX_DIM_EN, ROW_CYCLES=8, brightness=1, pixel lit -> column low for 2 of 8 SHOW cycles; brightness=7 -> low all 8.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 RGB matrix scanner: colour bit indices,
// matrix geometry, scan state encoding, one display row word, dimming helper.
package matrix_pkg;

  localparam int R_IDX    = 2;
  localparam int G_IDX    = 1;
  localparam int B_IDX    = 0;
  localparam int RC_W     = 3;
  localparam int MAT_SIZE = 8;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [MAT_SIZE-1:0] r;
    logic [MAT_SIZE-1:0] g;
    logic [MAT_SIZE-1:0] b;
  } row_word_t;

  // Lit portion of a SHOW dwell for a 3-bit brightness level; never below one cycle.
  function automatic int dim_cycles(input logic [2:0] level, input int row_cycles);
    int n;
    n = ((int'(level) + 1) * row_cycles) / 8;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/matrix_frame_scanner_if.sv
// Game-side pixel write / clear / swap bus of the matrix scanner.
// master = game logic, slave = scanner; swap_ack and busy flow back to the game.
interface matrix_frame_scanner_if;
  import matrix_pkg::*;

  logic            wr_en;
  logic [RC_W-1:0] wr_row;
  logic [RC_W-1:0] wr_col;
  logic [2:0]      wr_rgb;
  logic            wr_clr;
  logic            swap_req;
  logic            swap_ack;
  logic            busy;

  modport master (
    output wr_en, wr_row, wr_col, wr_rgb, wr_clr, swap_req,
    input  swap_ack, busy
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_rgb, wr_clr, swap_req,
    output swap_ack, busy
  );

endinterface

// File: rtl/matrix_frame_buf.sv
// Two 8x8 RGB frame buffers with front index: single-pixel writes and an 8-cycle row-by-row
// clear target the back buffer; swap flips the front index; front row read is combinational.
module matrix_frame_buf
  import matrix_pkg::*;
(
  input  logic            CLK,
  input  logic            Clear,
  input  logic            wr_en,
  input  logic [RC_W-1:0] wr_row,
  input  logic [RC_W-1:0] wr_col,
  input  logic [2:0]      wr_rgb,
  input  logic            wr_clr,
  input  logic            swap,
  input  logic [RC_W-1:0] rd_row,
  output row_word_t       rd_word,
  output logic            busy
);

  row_word_t       r_buf [2][MAT_SIZE];
  logic            r_front;
  logic            r_busy;
  logic [RC_W-1:0] r_clr_row;
  logic            w_back;

  assign w_back = ~r_front;

  // Swap is only granted while idle, so a clear always finishes in the buffer it started in.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_buf     <= '{default: '0};
      r_front   <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_row <= '0;
    end else begin
      if (swap) begin
        r_front <= ~r_front;
      end
      if (r_busy) begin
        r_buf[w_back][r_clr_row] <= '0;
        r_clr_row                <= r_clr_row + 1'b1;
        if (r_clr_row == RC_W'(MAT_SIZE - 1)) begin
          r_busy <= 1'b0;
        end
      end else if (wr_clr) begin
        r_busy    <= 1'b1;
        r_clr_row <= '0;
      end else if (wr_en) begin
        r_buf[w_back][wr_row].r[wr_col] <= wr_rgb[R_IDX];
        r_buf[w_back][wr_row].g[wr_col] <= wr_rgb[G_IDX];
        r_buf[w_back][wr_row].b[wr_col] <= wr_rgb[B_IDX];
      end
    end
  end

  assign rd_word = r_buf[r_front][rd_row];
  assign busy    = r_busy;

endmodule

// File: rtl/matrix_frame_scanner.sv
// Scans the front buffer row by row (BLANK then SHOW) onto active-low columns; registered outputs.
// Swaps at the last SHOW cycle of row 7 when requested and idle; MATRIX_DIM_EN adds brightness PWM.
module matrix_frame_scanner
  import matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  Clear,
  matrix_frame_scanner_if.slave bus,
`ifdef MATRIX_DIM_EN
  input  logic [2:0]            brightness,
`endif
  output logic                  frame_start,
  output logic [MAT_SIZE-1:0]   position_R,
  output logic [MAT_SIZE-1:0]   position_G,
  output logic [MAT_SIZE-1:0]   position_B,
  output logic [RC_W-1:0]       S
);

  localparam int MAXC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t         r_state;
  logic [RC_W-1:0]     r_row;
  logic [CW-1:0]       r_cnt;
  logic [MAT_SIZE-1:0] r_pos_r;
  logic [MAT_SIZE-1:0] r_pos_g;
  logic [MAT_SIZE-1:0] r_pos_b;
  logic                r_frame_start;
  logic                r_swap_ack;
`ifdef MATRIX_DIM_EN
  logic [CW-1:0]       r_lit;
`endif

  row_word_t w_rd_word;
  logic      w_busy;
  logic      w_boundary;
  logic      w_swap;

  assign w_boundary = (r_state == SHOW) && (r_row == RC_W'(MAT_SIZE - 1)) && (r_cnt == ROW_LAST);
  assign w_swap     = w_boundary && bus.swap_req && !w_busy;

  matrix_frame_buf u_buf (
    .CLK     (CLK),
    .Clear   (Clear),
    .wr_en   (bus.wr_en),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_rgb  (bus.wr_rgb),
    .wr_clr  (bus.wr_clr),
    .swap    (w_swap),
    .rd_row  (r_row),
    .rd_word (w_rd_word),
    .busy    (w_busy)
  );

  // Column registers load on the BLANK->SHOW edge so the row lights on its first SHOW cycle.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_state       <= BLANK;
      r_row         <= '0;
      r_cnt         <= '0;
      r_pos_r       <= '1;
      r_pos_g       <= '1;
      r_pos_b       <= '1;
      r_frame_start <= 1'b0;
      r_swap_ack    <= 1'b0;
`ifdef MATRIX_DIM_EN
      r_lit         <= '0;
`endif
    end else begin
      r_frame_start <= 1'b0;
      r_swap_ack    <= w_swap;
      case (r_state)
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state       <= SHOW;
            r_cnt         <= '0;
            r_pos_r       <= ~w_rd_word.r;
            r_pos_g       <= ~w_rd_word.g;
            r_pos_b       <= ~w_rd_word.b;
            r_frame_start <= (r_row == '0);
`ifdef MATRIX_DIM_EN
            r_lit         <= CW'(dim_cycles(brightness, ROW_CYCLES));
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (r_cnt == ROW_LAST) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_row   <= r_row + 1'b1;
            r_pos_r <= '1;
            r_pos_g <= '1;
            r_pos_b <= '1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`ifdef MATRIX_DIM_EN
            if ((r_cnt + 1'b1) >= r_lit) begin
              r_pos_r <= '1;
              r_pos_g <= '1;
              r_pos_b <= '1;
            end
`endif
          end
        end
      endcase
    end
  end

  assign bus.swap_ack = r_swap_ack;
  assign bus.busy     = w_busy;
  assign frame_start  = r_frame_start;
  assign position_R   = r_pos_r;
  assign position_G   = r_pos_g;
  assign position_B   = r_pos_b;
  assign S            = r_row;

endmodule

// File: tb/tb_matrix_frame_scanner.sv
// Bench for matrix_frame_scanner: directed scenarios plus random traffic against a frame-level model.
module tb_matrix_frame_scanner;

  localparam int RC    = 4;
  localparam int BC    = 2;
  localparam int RL    = RC + BC;
  localparam int FRAME = 8 * RL;
  localparam logic [29:0] RESET_VEC = {3'd0, 24'hFF_FFFF, 3'b000};

  logic       CLK   = 1'b0;
  logic       Clear = 1'b0;
  logic       frame_start;
  logic [7:0] position_R, position_G, position_B;
  logic [2:0] S;
`ifdef MATRIX_DIM_EN
  logic [2:0] brightness = 3'd7;
`endif

  matrix_frame_scanner_if bus ();

  matrix_frame_scanner #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .CLK         (CLK),
    .Clear       (Clear),
    .bus         (bus),
`ifdef MATRIX_DIM_EN
    .brightness  (brightness),
`endif
    .frame_start (frame_start),
    .position_R  (position_R),
    .position_G  (position_G),
    .position_B  (position_B),
    .S           (S)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  wire [29:0] w_obs = {S, position_R, position_G, position_B, frame_start, bus.swap_ack, bus.busy};

  // Frame-level model: cycle index since reset, pixel arrays, front index, clear countdown.
  int         m_t;
  bit         m_front;
  bit         m_back;
  bit         m_swap;
  bit         m_ack;
  int         m_busy;
  logic [2:0] m_px [2][8][8];

  always @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      m_t = 0; m_front = 0; m_busy = 0; m_ack = 0;
      for (int b = 0; b < 2; b++) for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) m_px[b][y][x] = 3'b000;
    end else begin
      m_back = !m_front;
      m_swap = ((m_t % FRAME) == FRAME - 1) && bus.swap_req && (m_busy == 0);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) m_px[m_back][y][x] = 3'b000;
      end else if (bus.wr_clr) begin
        m_busy = 8;
      end else if (bus.wr_en) begin
        m_px[m_back][bus.wr_row][bus.wr_col] = bus.wr_rgb;
      end
      if (m_swap) m_front = !m_front;
      m_ack = m_swap;
      m_t++;
    end
  end

  function automatic logic [29:0] exp_vec();
    int p, row, ph, n;
    bit lit;
    logic [7:0] r, g, b;
    p = m_t % FRAME; row = p / RL; ph = p % RL;
    r = 8'hFF; g = 8'hFF; b = 8'hFF;
    lit = (ph >= BC);
`ifdef MATRIX_DIM_EN
    n = ((int'(brightness) + 1) * RC) / 8;
    if (n < 1) n = 1;
    if (lit && (ph - BC) >= n) lit = 0;
`else
    n = 0;
`endif
    if (lit) for (int c = 0; c < 8; c++) begin
      r[c] = !m_px[m_front][row][c][2];
      g[c] = !m_px[m_front][row][c][1];
      b[c] = !m_px[m_front][row][c][0];
    end
    return {3'(row), r, g, b, (p == BC), m_ack, (m_busy != 0)};
  endfunction

  task automatic idle_until(input int target);
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge CLK);
      if ((m_t % FRAME) == target) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL reset got=%h expected=%h", w_obs, RESET_VEC); end
    end
    Clear = 1'b1;
  endtask

  task automatic test_scan_timing();
    int fs_first, fs_count;
    fs_first = -1; fs_count = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL scan k=%0d got=%h expected=%h", k, w_obs, exp_vec()); end
      n_cmp++;
      if (S !== 3'((k % FRAME) / RL) || {position_R, position_G, position_B} !== 24'hFF_FFFF) begin
        n_bad++; $display("FAIL scan_rows k=%0d got S=%0d cols=%h expected S=%0d cols=ffffff", k, S, {position_R, position_G, position_B}, (k % FRAME) / RL);
      end
      if (frame_start) begin
        fs_count++;
        if (fs_first < 0) fs_first = k;
      end
    end
    n_cmp++;
    if (fs_first != BC || fs_count != 2) begin n_bad++; $display("FAIL frame_start first=%0d count=%0d expected first=%0d count=2", fs_first, fs_count, BC); end
  endtask

  task automatic test_write_swap();
    bit got;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL ws_pre got=%h expected=%h", w_obs, exp_vec()); end
      bus.wr_en = 1'b1; bus.wr_row = 3'($urandom_range(0, 6)); bus.wr_col = 3'($urandom_range(0, 7)); bus.wr_rgb = 3'($urandom_range(0, 7));
      if (bus.wr_row == 3'd3) bus.wr_row = 3'd7;
    end
    @(negedge CLK);
    bus.wr_row = 3'd3; bus.wr_col = 3'd5; bus.wr_rgb = 3'b100;
    @(negedge CLK);
    bus.wr_en = 1'b0; bus.swap_req = 1'b1;
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL ws_wait got=%h expected=%h", w_obs, exp_vec()); end
      if (bus.swap_ack) begin
        got = 1; bus.swap_req = 1'b0;
        n_cmp++;
        if ((m_t % FRAME) != 0) begin n_bad++; $display("FAIL ws_ack_phase got=%0d expected=0", m_t % FRAME); end
      end else if ({position_R, position_G, position_B} !== 24'hFF_FFFF) begin
        n_cmp++; n_bad++; $display("FAIL ws_early got=%h expected=ffffff", {position_R, position_G, position_B});
      end
    end
    n_cmp++;
    if (!got) begin n_bad++; bus.swap_req = 1'b0; $display("FAIL ws_ack got=timeout expected=ack"); end
    idle_until(3 * RL + BC);
    n_cmp++;
    if ({position_R, position_G, position_B} !== {8'b11011111, 16'hFFFF}) begin
      n_bad++; $display("FAIL ws_row3 got=%h expected=%h", {position_R, position_G, position_B}, {8'b11011111, 16'hFFFF});
    end
  endtask

  task automatic test_clear_defer();
    int busy_n, ack_k, nonff;
    busy_n = 0; ack_k = -1; nonff = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.wr_en = 1'b1; bus.wr_row = 3'($urandom_range(0, 7)); bus.wr_col = 3'($urandom_range(0, 7)); bus.wr_rgb = 3'($urandom_range(1, 7));
    end
    @(negedge CLK);
    bus.wr_en = 1'b0;
    idle_until(42);
    bus.wr_clr = 1'b1;
    for (int k = 0; k < 54 + FRAME; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL cd_model k=%0d got=%h expected=%h", k, w_obs, exp_vec()); end
      if (bus.busy) busy_n++;
      if (ack_k >= 0 && {position_R, position_G, position_B} !== 24'hFF_FFFF) nonff++;
      if (bus.swap_ack && ack_k < 0) begin ack_k = k; bus.swap_req = 1'b0; end
      bus.wr_clr = 1'b0;
      if (k == 1) bus.swap_req = 1'b1;
      bus.wr_en = (k == 2);
      if (k == 2) begin bus.wr_row = 3'd2; bus.wr_col = 3'd2; bus.wr_rgb = 3'b111; end
    end
    bus.swap_req = 1'b0;
    n_cmp++;
    if (busy_n != 8) begin n_bad++; $display("FAIL cd_busy got=%0d expected=8", busy_n); end
    n_cmp++;
    if (ack_k != 53) begin n_bad++; $display("FAIL cd_defer got=%0d expected=53", ack_k); end
    n_cmp++;
    if (nonff != 0) begin n_bad++; $display("FAIL cd_blank got=%0d lit cycles expected=0", nonff); end
  endtask

  task automatic test_sim_write_swap();
    @(negedge CLK);
    bus.wr_clr = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      bus.wr_clr = 1'b0;
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL sws_clr got=%h expected=%h", w_obs, exp_vec()); end
    end
    bus.wr_en = 1'b1; bus.wr_row = 3'd5; bus.wr_col = 3'd4; bus.wr_rgb = 3'b111;
    @(negedge CLK);
    bus.wr_en = 1'b0;
    idle_until(FRAME - 1);
    bus.swap_req = 1'b1; bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_col = 3'd0; bus.wr_rgb = 3'b011;
    @(negedge CLK);
    bus.wr_en = 1'b0; bus.swap_req = 1'b0;
    n_cmp++;
    if (bus.swap_ack !== 1'b1) begin n_bad++; $display("FAIL sws_ack got=%b expected=1", bus.swap_ack); end
    idle_until(BC);
    n_cmp++;
    if ({position_R, position_G, position_B} !== {8'hFF, 8'hFE, 8'hFE}) begin
      n_bad++; $display("FAIL sws_row0 got=%h expected=fffefe", {position_R, position_G, position_B});
    end
  endtask

  task automatic test_midframe_reset();
    idle_until(5 * RL + BC + 1);
    n_cmp++;
    if ({S, position_R} !== {3'd5, 8'hEF}) begin n_bad++; $display("FAIL mfr_pre got=%h expected=%h", {S, position_R}, {3'd5, 8'hEF}); end
    bus.swap_req = 1'b1;
    #2 Clear = 1'b0;
    #1;
    n_cmp++;
    if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL mfr_async got=%h expected=%h", w_obs, RESET_VEC); end
    repeat (3) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL mfr_hold got=%h expected=%h", w_obs, RESET_VEC); end
    end
    bus.swap_req = 1'b0;
    Clear = 1'b1;
    repeat (FRAME + 4) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec() || bus.swap_ack || {position_R, position_G, position_B} !== 24'hFF_FFFF) begin
        n_bad++; $display("FAIL mfr_after got=%h expected=%h", w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL random i=%0d got=%h expected=%h", i, w_obs, exp_vec()); end
      bus.wr_en  = ($urandom_range(0, 2) == 0);
      bus.wr_row = 3'($urandom_range(0, 7));
      bus.wr_col = 3'($urandom_range(0, 7));
      bus.wr_rgb = 3'($urandom_range(0, 7));
      bus.wr_clr = ($urandom_range(0, 50) == 0);
      if (bus.swap_ack) bus.swap_req = 1'b0;
      else if (!bus.swap_req && $urandom_range(0, 20) == 0) bus.swap_req = 1'b1;
    end
    @(negedge CLK);
    bus.wr_en = 1'b0; bus.wr_clr = 1'b0; bus.swap_req = 1'b0;
  endtask

`ifdef MATRIX_DIM_EN
  task automatic test_dim();
    bit got;
    int lows;
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge CLK);
    bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_col = 3'd0; bus.wr_rgb = 3'b100;
    @(negedge CLK);
    bus.wr_en = 1'b0; bus.swap_req = 1'b1;
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      @(negedge CLK);
      if (bus.swap_ack) got = 1;
    end
    bus.swap_req = 1'b0;
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL dim_swap got=timeout expected=ack"); end
    brightness = 3'd1;
    lows = 0;
    repeat (RL - 1) begin
      @(negedge CLK);
      n_cmp++;
      if (w_obs !== exp_vec()) begin n_bad++; $display("FAIL dim_model got=%h expected=%h", w_obs, exp_vec()); end
      if (position_R[0] === 1'b0) lows++;
    end
    n_cmp++;
    if (lows != 1) begin n_bad++; $display("FAIL dim_b1 got=%0d expected=1", lows); end
    idle_until(0);
    brightness = 3'd7;
    lows = 0;
    repeat (RL - 1) begin
      @(negedge CLK);
      if (position_R[0] === 1'b0) lows++;
    end
    n_cmp++;
    if (lows != RC) begin n_bad++; $display("FAIL dim_b7 got=%0d expected=%0d", lows, RC); end
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0; bus.wr_row = 3'd0; bus.wr_col = 3'd0; bus.wr_rgb = 3'd0;
    bus.wr_clr = 1'b0; bus.swap_req = 1'b0;
    test_reset();
    test_scan_timing();
    test_write_swap();
    test_clear_defer();
    test_sim_write_swap();
    test_midframe_reset();
    test_random();
`ifdef MATRIX_DIM_EN
    test_dim();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
